memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the ports wr_reg_en_mem, link_mem, mem_wr_mem, load_hb_mem, sign_zero_ext_mem, mfhi_mem, mflo_mem, hi_wr_en_mem and lo_wr_en_mem, each input, 1 bit: control fields from the execute register.
REQ-004 The module SHALL have the ports mem_to_reg_mem and store_hb_mem, input, 2 bits each, and wr_reg_addr_mem, input, 5 bits.
REQ-005 The module SHALL have the ports alu_to_mem, sourceB_mem, PC4_mem, hi_lo_mem, res_hi_mem and res_lo_mem, input, 32 bits each.
REQ-006 The module SHALL have the ports dmem_req, dmem_we and dmem_be[3:0], output; dmem_addr and dmem_wdata, output, 32 bits; dmem_rdata, input, 32 bits; dmem_ack, input, 1 bit.
REQ-007 The module SHALL have the ports stall_mem, output, 1 bit (hold upstream stages) and misalign_trap, output, 1 bit.
REQ-008 The module SHALL have the write-back register outputs wr_reg_en_wb, link_wb, mfhi_wb, mflo_wb, hi_wr_en_wb, lo_wr_en_wb (1 bit), mem_to_reg_wb (2 bits), wr_reg_addr_wb (5 bits), and alu_to_wb, read_data_wb, PC4_wb, hi_lo_wb, res_hi_wb, res_lo_wb (32 bits).

Function
REQ-009 An access SHALL be a load when mem_to_reg_mem==2'b01 and a store when mem_wr_mem==1; any other instruction SHALL be a non-access.
REQ-010 Size SHALL be word when load_hb_mem==0 for loads and store_hb_mem==00 for stores; half when store_hb_mem==01; byte when store_hb_mem==10; the encoding 11 SHALL be treated as word.
REQ-011 The FSM SHALL have the states IDLE and WAIT; it SHALL go IDLE->WAIT when an aligned access is present and WAIT->IDLE in the cycle dmem_ack==1.
REQ-012 dmem_req SHALL be 1 in IDLE when an access is present and throughout WAIT; dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be held stable until ack.
REQ-013 stall_mem SHALL equal dmem_req AND NOT dmem_ack, combinationally.
REQ-014 dmem_ack SHALL be honoured only while dmem_req==1; an ack in the same cycle as the first req SHALL complete the access with zero wait states.
REQ-015 Byte enables SHALL be little-endian: byte n -> be bit addr[1:0]; half at addr[1]=0 -> 0011 and at addr[1]=1 -> 1100; word -> 1111.
REQ-016 Store data SHALL be replicated: a byte SHALL be replicated into all four lanes and a half into both halves.
REQ-017 Load data SHALL be extracted from the addressed lane and sign-extended when sign_zero_ext_mem==1, else zero-extended.
REQ-018 The extracted load data SHALL be registered into read_data_wb.
REQ-019 Non-access instructions SHALL pass to the write-back registers in 1 cycle; an access SHALL take 1+N cycles, where N is the number of wait cycles.
REQ-020 While stall_mem==1, the write-back registers SHALL be loaded with a bubble: all write enables 0 and data fields unchanged.
REQ-021 When the trap condition is active, no request SHALL be issued, misalign_trap SHALL pulse high for 1 cycle, and the write-back registers SHALL receive a bubble.

Reset
REQ-022 On reset, the FSM SHALL go to IDLE, and dmem_req, stall_mem, misalign_trap and all write-back outputs SHALL be 0.
REQ-023 Reset asserted in WAIT SHALL abandon the access, drop dmem_req the next cycle, and ignore any late ack.

Configuration
REQ-024 The macro MEM_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-025 When MEM_MISALIGN_TRAP_EN is defined, a half access with addr[0]!=0, or a word access with addr[1:0]!=0, SHALL raise misalign_trap per REQ-021.
REQ-026 When MEM_MISALIGN_TRAP_EN is undefined, misalign_trap SHALL be tied 0 and the address low bits SHALL be forced to zero (half: bit0; word: bits1:0) before use.

Structure
REQ-027 Package mem_pkg SHALL hold the access-size enum (WORD, HALF, BYTE), the FSM state enum and the mem_to_reg load encoding constant.
REQ-028 One sub-module, load_align, SHALL implement the combinational lane extraction and extension.

Verification
REQ-029 A word store to 0x100 with data 0xDEADBEEF and ack after 2 cycles SHALL produce be=1111, req high for 3 cycles, stall_mem high for 2 cycles and no write-back enable.
REQ-030 A byte load from 0x203 with rdata=0x80112233 and sign=1 SHALL produce be=1000 and read_data_wb=0xFFFFFF80; with sign=0 it SHALL produce 0x00000080.
REQ-031 A half store of 0x0000ABCD to 0x302 SHALL produce be=1100 and wdata=0xABCDABCD.
REQ-032 A zero-wait load (ack with req) followed by an ALU instruction SHALL have the two results arrive in write-back on consecutive cycles with no stall.
REQ-033 With MEM_MISALIGN_TRAP_EN defined, a word load from 0x101 SHALL produce no req, a 1-cycle misalign_trap and wr_reg_en_wb=0; with it undefined, the same load SHALL access 0x100.
REQ-034 Reset asserted during WAIT followed by an ack one cycle later SHALL leave dmem_req=0, the FSM in IDLE, and no write-back.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory stage.
//   size_e      - access size decoded from the load/store size fields
//   state_e     - data-memory handshake FSM state
//   wb_regs_t   - write-back pipeline register contents
//   MEM_TO_REG_LOAD - mem_to_reg encoding that selects a load
//   decode_size - maps the load_hb/store_hb control fields to size_e
package mem_pkg;

  typedef enum logic [1:0] {
    WORD = 2'd0,
    HALF = 2'd1,
    BYTE = 2'd2
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;

  typedef struct packed {
    logic        wr_reg_en;
    logic        link;
    logic        mfhi;
    logic        mflo;
    logic        hi_wr_en;
    logic        lo_wr_en;
    logic [1:0]  mem_to_reg;
    logic [4:0]  wr_reg_addr;
    logic [31:0] alu;
    logic [31:0] read_data;
    logic [31:0] pc4;
    logic [31:0] hi_lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
  } wb_regs_t;

  // A load with load_hb clear is always a word; otherwise the store_hb
  // field carries the size (11 falls back to word).
  function automatic size_e decode_size(input logic       is_load,
                                        input logic       load_hb,
                                        input logic [1:0] store_hb);
    size_e s;
    s = WORD;
    if (!(is_load && !load_hb)) begin
      case (store_hb)
        2'b01:   s = HALF;
        2'b10:   s = BYTE;
        default: s = WORD;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/half/word lane from the read
// data bus and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports:
//   rdata_i   - raw 32-bit word from data memory
//   addr_lo_i - byte offset within the word
//   size_i    - access size
//   sign_i    - 1: sign-extend, 0: zero-extend
//   data_o    - aligned, extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      BYTE:    data_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
      HALF:    data_o = {{16{sign_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage. Issues load/store requests on a
// req/ack data-memory port, stalls upstream until ack, aligns load data and
// registers all results into the write-back pipeline registers.
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses raise misalign_trap, no request
//   undefined - misalign_trap is 0 and the offending low address bits are
//               forced to zero
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   *_mem                 - control/data fields from the execute register
//   dmem_*                - data-memory request interface
//   stall_mem             - holds upstream stages while a request is pending
//   misalign_trap         - one-cycle pulse on a trapped access
//   *_wb                  - write-back register outputs
module memory_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_reg_en_mem,
  input  logic        link_mem,
  input  logic        mem_wr_mem,
  input  logic        load_hb_mem,
  input  logic        sign_zero_ext_mem,
  input  logic        mfhi_mem,
  input  logic        mflo_mem,
  input  logic        hi_wr_en_mem,
  input  logic        lo_wr_en_mem,
  input  logic [1:0]  mem_to_reg_mem,
  input  logic [1:0]  store_hb_mem,
  input  logic [4:0]  wr_reg_addr_mem,
  input  logic [31:0] alu_to_mem,
  input  logic [31:0] sourceB_mem,
  input  logic [31:0] PC4_mem,
  input  logic [31:0] hi_lo_mem,
  input  logic [31:0] res_hi_mem,
  input  logic [31:0] res_lo_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        misalign_trap,
  output logic        wr_reg_en_wb,
  output logic        link_wb,
  output logic        mfhi_wb,
  output logic        mflo_wb,
  output logic        hi_wr_en_wb,
  output logic        lo_wr_en_wb,
  output logic [1:0]  mem_to_reg_wb,
  output logic [4:0]  wr_reg_addr_wb,
  output logic [31:0] alu_to_wb,
  output logic [31:0] read_data_wb,
  output logic [31:0] PC4_wb,
  output logic [31:0] hi_lo_wb,
  output logic [31:0] res_hi_wb,
  output logic [31:0] res_lo_wb
);

  logic        is_load;
  logic        is_store;
  logic        access;
  size_e       size;
  logic [31:0] addr_eff;
  logic        trap;
  logic        bubble;
  logic [31:0] load_data;
  state_e      state_q, state_d;
  wb_regs_t    wb_q, wb_d;

  assign is_load  = (mem_to_reg_mem == MEM_TO_REG_LOAD);
  assign is_store = mem_wr_mem;
  assign access   = is_load | is_store;
  assign size     = decode_size(is_load & ~is_store, load_hb_mem, store_hb_mem);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      HALF:    misaligned = alu_to_mem[0];
      WORD:    misaligned = |alu_to_mem[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign addr_eff = alu_to_mem;
  // Only a fresh access can trap; WAIT is only ever entered when aligned.
  assign trap     = ~reset & access & misaligned & (state_q == IDLE);
`else
  always_comb begin
    addr_eff = alu_to_mem;
    case (size)
      HALF:    addr_eff[0]   = 1'b0;
      WORD:    addr_eff[1:0] = 2'b00;
      default: addr_eff      = alu_to_mem;
    endcase
  end

  assign trap = 1'b0;
`endif

  // Upstream holds the instruction while stalled, so the request fields
  // derived from it stay stable until ack without extra capture registers.
  assign dmem_req      = ~reset & ((state_q == WAIT) | (access & ~trap));
  assign stall_mem     = dmem_req & ~dmem_ack;
  assign misalign_trap = trap;
  assign dmem_addr     = addr_eff;
  assign dmem_we       = is_store;

  always_comb begin
    case (size)
      BYTE: begin
        dmem_be    = 4'b0001 << addr_eff[1:0];
        dmem_wdata = {4{sourceB_mem[7:0]}};
      end
      HALF: begin
        dmem_be    = addr_eff[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{sourceB_mem[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = sourceB_mem;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_eff[1:0]),
    .size_i    (size),
    .sign_i    (sign_zero_ext_mem),
    .data_o    (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem_req && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bubble = stall_mem | trap;

  always_comb begin
    wb_d.wr_reg_en   = wr_reg_en_mem;
    wb_d.link        = link_mem;
    wb_d.mfhi        = mfhi_mem;
    wb_d.mflo        = mflo_mem;
    wb_d.hi_wr_en    = hi_wr_en_mem;
    wb_d.lo_wr_en    = lo_wr_en_mem;
    wb_d.mem_to_reg  = mem_to_reg_mem;
    wb_d.wr_reg_addr = wr_reg_addr_mem;
    wb_d.alu         = alu_to_mem;
    wb_d.read_data   = load_data;
    wb_d.pc4         = PC4_mem;
    wb_d.hi_lo       = hi_lo_mem;
    wb_d.res_hi      = res_hi_mem;
    wb_d.res_lo      = res_lo_mem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        // Bubble: drop every write enable, leave data fields as they were.
        wb_q.wr_reg_en <= 1'b0;
        wb_q.hi_wr_en  <= 1'b0;
        wb_q.lo_wr_en  <= 1'b0;
      end else begin
        wb_q <= wb_d;
      end
    end
  end

  assign wr_reg_en_wb   = wb_q.wr_reg_en;
  assign link_wb        = wb_q.link;
  assign mfhi_wb        = wb_q.mfhi;
  assign mflo_wb        = wb_q.mflo;
  assign hi_wr_en_wb    = wb_q.hi_wr_en;
  assign lo_wr_en_wb    = wb_q.lo_wr_en;
  assign mem_to_reg_wb  = wb_q.mem_to_reg;
  assign wr_reg_addr_wb = wb_q.wr_reg_addr;
  assign alu_to_wb      = wb_q.alu;
  assign read_data_wb   = wb_q.read_data;
  assign PC4_wb         = wb_q.pc4;
  assign hi_lo_wb       = wb_q.hi_lo;
  assign res_hi_wb      = wb_q.res_hi;
  assign res_lo_wb      = wb_q.res_lo;

endmodule
